// File: rtl/screen_write_sched.sv
// Single-port write scheduler for the 6912-byte Spectrum screen buffer.
// Arbitrates CPU write snoop, bulk loader and clear engine; all write outputs are registered.
module screen_write_sched #(
    parameter int          BUFFER_SIZE = 6912,
    parameter int          BITMAP_SIZE = 6144,
    parameter logic [15:0] BASE_ADDR   = 16'h4000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        ld_valid_i,
    input  logic [12:0] ld_addr_i,
    input  logic [7:0]  ld_data_i,
    output logic        ld_ready_o,
    input  logic        clr_start_i,
    input  logic [7:0]  clr_bitmap_i,
    input  logic [7:0]  clr_attr_i,
    output logic        clr_busy_o,
    output logic        clr_done_o,
    output logic        ld_err_o,
    output logic        buf_we_o,
    output logic [12:0] buf_addr_o,
    output logic [7:0]  buf_data_o
);

    localparam logic [15:0] BUF_SIZE16 = 16'(BUFFER_SIZE);
    localparam logic [12:0] BUF_SIZE13 = 13'(BUFFER_SIZE);
    localparam logic [12:0] BMP_SIZE13 = 13'(BITMAP_SIZE);
    localparam logic [12:0] LAST_OFF   = 13'(BUFFER_SIZE - 1);

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_CLEAR = 1'b1;

    logic        state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [7:0]  fill_bmp_q, fill_bmp_d;
    logic [7:0]  fill_attr_q, fill_attr_d;
    logic        buf_we_q, buf_we_d;
    logic [12:0] buf_addr_q, buf_addr_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        clr_done_q, clr_done_d;
    logic        ld_err_q, ld_err_d;

    logic [15:0] cpu_off;
    logic        cpu_hit;
    logic        ld_fire;
    logic        ld_in_range;
    logic [7:0]  clr_fill;

    // Subtraction wraps modulo 2^16, so addresses below BASE_ADDR land far out of range.
    assign cpu_off     = cpu_addr_i - BASE_ADDR;
    assign cpu_hit     = cpu_we_i && (cpu_off < BUF_SIZE16);
    assign ld_ready_o  = (state_q == STATE_IDLE) && !cpu_hit && !reset_i;
    assign ld_fire     = ld_valid_i && ld_ready_o;
    assign ld_in_range = ld_addr_i < BUF_SIZE13;
    assign clr_fill    = (cnt_q < BMP_SIZE13) ? fill_bmp_q : fill_attr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_bmp_d  = fill_bmp_q;
        fill_attr_d = fill_attr_q;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        clr_done_d  = 1'b0;
        ld_err_d    = ld_err_q;

        if (cpu_hit) begin
            buf_we_d   = 1'b1;
            buf_addr_d = cpu_off[12:0];
            buf_data_d = cpu_data_i;
        end else if (state_q == STATE_CLEAR) begin
            // Clear only advances on cycles the CPU leaves the port free.
            buf_we_d   = 1'b1;
            buf_addr_d = cnt_q;
            buf_data_d = clr_fill;
            if (cnt_q == LAST_OFF) begin
                state_d    = STATE_IDLE;
                cnt_d      = 13'd0;
                clr_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 13'd1;
            end
        end else if (ld_fire) begin
            if (ld_in_range) begin
                buf_we_d   = 1'b1;
                buf_addr_d = ld_addr_i;
                buf_data_d = ld_data_i;
            end else begin
                ld_err_d = 1'b1;
            end
        end

        // A loader byte accepted in the start cycle is still issued above; clearing begins next cycle.
        if ((state_q == STATE_IDLE) && clr_start_i) begin
            state_d     = STATE_CLEAR;
            cnt_d       = 13'd0;
            fill_bmp_d  = clr_bitmap_i;
            fill_attr_d = clr_attr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= STATE_IDLE;
            cnt_q       <= 13'd0;
            fill_bmp_q  <= 8'd0;
            fill_attr_q <= 8'd0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= 13'd0;
            buf_data_q  <= 8'd0;
            clr_done_q  <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_bmp_q  <= fill_bmp_d;
            fill_attr_q <= fill_attr_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            clr_done_q  <= clr_done_d;
            ld_err_q    <= ld_err_d;
        end
    end

    assign clr_busy_o = (state_q == STATE_CLEAR);
    assign clr_done_o = clr_done_q;
    assign ld_err_o   = ld_err_q;
    assign buf_we_o   = buf_we_q;
    assign buf_addr_o = buf_addr_q;
    assign buf_data_o = buf_data_q;

endmodule

// File: tb/tb_screen_write_sched.sv
// Bench for screen_write_sched: directed vector table, clear-engine sequences and random traffic
// checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_screen_write_sched;

    logic        clk = 1'b0;
    logic        reset, cpu_we, ld_valid, clr_start;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data, ld_data, clr_bitmap, clr_attr;
    logic [12:0] ld_addr;
    logic        ld_ready, clr_busy, clr_done, ld_err, buf_we;
    logic [12:0] buf_addr;
    logic [7:0]  buf_data;

    always #5 clk = ~clk;

    screen_write_sched dut (
        .clk_i(clk), .reset_i(reset),
        .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
        .clr_start_i(clr_start), .clr_bitmap_i(clr_bitmap), .clr_attr_i(clr_attr),
        .clr_busy_o(clr_busy), .clr_done_o(clr_done), .ld_err_o(ld_err),
        .buf_we_o(buf_we), .buf_addr_o(buf_addr), .buf_data_o(buf_data)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: whether a clear is running, the next offset it will fill, latched fills,
    // sticky error, and the expected registered outputs.
    bit m_clr, m_err, m_we, m_done;
    int m_next, m_fb, m_fa, m_addr, m_data;

    task automatic idle_inputs();
        reset = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_data = 8'h00;
        ld_valid = 1'b0; ld_addr = 13'd0; ld_data = 8'h00;
        clr_start = 1'b0; clr_bitmap = 8'h00; clr_attr = 8'h00;
    endtask

    // Apply the current inputs for one clock, predict, then compare registered outputs.
    task automatic tick();
        int  off;
        bit  hit, rdy, was_clr;
        #1;
        off = (int'(cpu_addr) - 16384) & 'hFFFF;
        hit = cpu_we && (off < 6912);
        rdy = !reset && !m_clr && !hit;
        chk("ld_ready", int'(ld_ready), int'(rdy));
        was_clr = m_clr;
        m_we = 0; m_done = 0;
        if (reset) begin
            m_clr = 0; m_next = 0; m_err = 0; m_addr = 0; m_data = 0;
        end else begin
            if (hit) begin
                m_we = 1; m_addr = off; m_data = cpu_data;
            end else if (was_clr) begin
                m_we = 1; m_addr = m_next;
                m_data = (m_next < 6144) ? m_fb : m_fa;
                m_next++;
                if (m_next == 6912) begin m_done = 1; m_clr = 0; m_next = 0; end
            end else if (ld_valid) begin
                if (ld_addr < 6912) begin m_we = 1; m_addr = ld_addr; m_data = ld_data; end
                else m_err = 1;
            end
            if (!was_clr && clr_start) begin
                m_clr = 1; m_next = 0; m_fb = clr_bitmap; m_fa = clr_attr;
            end
        end
        @(posedge clk); #1;
        chk("buf_we", int'(buf_we), int'(m_we));
        chk("buf_addr", int'(buf_addr), m_addr);
        chk("buf_data", int'(buf_data), m_data);
        chk("clr_done", int'(clr_done), int'(m_done));
        chk("clr_busy", int'(clr_busy), int'(m_clr));
        chk("ld_err", int'(ld_err), int'(m_err));
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit          cwe;
        logic [15:0] caddr;
        logic [7:0]  cdata;
        bit          lv;
        logic [12:0] laddr;
        logic [7:0]  ldata;
        bit          e_rdy;
        bit          e_we;
        logic [12:0] e_addr;
        logic [7:0]  e_data;
        bit          e_err;
    } vec_t;

    vec_t vt[11];

    initial begin
        int nw, nd, seqbad, n, r;

        vt[0]  = '{1, 16'h4000, 8'hAA, 0, 13'd0,    8'h00, 0, 1, 13'd0,    8'hAA, 0};
        vt[1]  = '{1, 16'h5AFF, 8'h55, 0, 13'd0,    8'h00, 0, 1, 13'd6911, 8'h55, 0};
        vt[2]  = '{1, 16'h5B00, 8'h11, 0, 13'd0,    8'h00, 1, 0, 13'd0,    8'h00, 0};
        vt[3]  = '{1, 16'h3FFF, 8'h22, 0, 13'd0,    8'h00, 1, 0, 13'd0,    8'h00, 0};
        vt[4]  = '{1, 16'hFFFF, 8'h33, 0, 13'd0,    8'h00, 1, 0, 13'd0,    8'h00, 0};
        vt[5]  = '{0, 16'h0000, 8'h00, 1, 13'd100,  8'h5A, 1, 1, 13'd100,  8'h5A, 0};
        vt[6]  = '{0, 16'h0000, 8'h00, 1, 13'd6911, 8'hC3, 1, 1, 13'd6911, 8'hC3, 0};
        vt[7]  = '{0, 16'h0000, 8'h00, 1, 13'd6912, 8'h01, 1, 0, 13'd0,    8'h00, 1};
        vt[8]  = '{0, 16'h0000, 8'h00, 1, 13'd8191, 8'h02, 1, 0, 13'd0,    8'h00, 1};
        vt[9]  = '{1, 16'h4064, 8'h11, 1, 13'd200,  8'h22, 0, 1, 13'd100,  8'h11, 0};
        vt[10] = '{0, 16'h4000, 8'h99, 1, 13'd5,    8'h66, 1, 1, 13'd5,    8'h66, 0};

        m_clr = 0; m_err = 0; m_next = 0; m_fb = 0; m_fa = 0; m_addr = 0; m_data = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        chk("rst_we", int'(buf_we), 0);
        chk("rst_addr", int'(buf_addr), 0);
        chk("rst_busy", int'(clr_busy), 0);
        reset = 1'b0;

        foreach (vt[i]) begin
            do_reset();
            cpu_we = vt[i].cwe; cpu_addr = vt[i].caddr; cpu_data = vt[i].cdata;
            ld_valid = vt[i].lv; ld_addr = vt[i].laddr; ld_data = vt[i].ldata;
            #1;
            chk($sformatf("vec%0d_rdy", i), int'(ld_ready), int'(vt[i].e_rdy));
            tick();
            chk($sformatf("vec%0d_we", i), int'(buf_we), int'(vt[i].e_we));
            if (vt[i].e_we) begin
                chk($sformatf("vec%0d_addr", i), int'(buf_addr), int'(vt[i].e_addr));
                chk($sformatf("vec%0d_data", i), int'(buf_data), int'(vt[i].e_data));
            end
            chk($sformatf("vec%0d_err", i), int'(ld_err), int'(vt[i].e_err));
        end

        // Loader stalled by a CPU hit is issued the following cycle.
        do_reset();
        cpu_we = 1; cpu_addr = 16'h4007; cpu_data = 8'h09;
        ld_valid = 1; ld_addr = 13'd100; ld_data = 8'h42;
        tick();
        cpu_we = 0;
        tick();
        chk("stall_ld_we", int'(buf_we), 1);
        chk("stall_ld_addr", int'(buf_addr), 100);
        chk("stall_ld_data", int'(buf_data), 'h42);

        // Sticky loader error survives idle cycles, clears on reset.
        ld_addr = 13'd6912;
        tick();
        idle_inputs();
        repeat (5) tick();
        chk("err_sticky", int'(ld_err), 1);
        do_reset();
        chk("err_cleared", int'(ld_err), 0);

        // Full clear, loader continuously offering; its start-cycle byte goes first.
        do_reset();
        clr_bitmap = 8'h00; clr_attr = 8'h38; clr_start = 1;
        ld_valid = 1; ld_addr = 13'd50; ld_data = 8'h77;
        tick();
        chk("coinc_ld_addr", int'(buf_addr), 50);
        clr_start = 0; clr_bitmap = 8'hFF; clr_attr = 8'hFF;
        nw = 0; nd = 0; seqbad = 0;
        for (int c = 0; c < 7000 && nd == 0; c++) begin
            tick();
            if (buf_we) begin
                if (int'(buf_addr) != nw || int'(buf_data) != ((nw < 6144) ? 0 : 'h38)) seqbad++;
                nw++;
            end
            if (clr_done) nd++;
        end
        chk("clr_writes", nw, 6912);
        chk("clr_done_cnt", nd, 1);
        chk("clr_seq_bad", seqbad, 0);
        tick();
        chk("ld_after_clr", int'(buf_addr), 50);
        chk("ld_after_we", int'(buf_we), 1);

        // Clear with three CPU hits interleaved stretches to 6915 cycles; clr_start mid-clear ignored.
        do_reset();
        clr_bitmap = 8'hA5; clr_attr = 8'h07; clr_start = 1;
        tick();
        clr_start = 0;
        n = 0;
        while (n < 7100) begin
            n++;
            cpu_we = (n == 100 || n == 2000 || n == 5000);
            cpu_addr = 16'h4000 + 16'(n); cpu_data = 8'(n);
            clr_start = (n == 3000);
            tick();
            if (clr_done) break;
        end
        chk("clr_cycles", n, 6915);

        // Reset with the counter at 1000 aborts without clr_done.
        do_reset();
        clr_start = 1;
        tick();
        clr_start = 0;
        repeat (1000) tick();
        reset = 1;
        tick();
        chk("abort_we", int'(buf_we), 0);
        chk("abort_busy", int'(clr_busy), 0);
        chk("abort_done", int'(clr_done), 0);
        reset = 0;
        nd = 0;
        repeat (20) begin tick(); if (clr_done || buf_we) nd++; end
        chk("abort_quiet", nd, 0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 15000; c++) begin
            reset = ($urandom_range(0, 2499) == 0);
            cpu_we = ($urandom_range(0, 9) < 3);
            r = $urandom_range(0, 9);
            if (r < 6) cpu_addr = 16'h4000 + 16'($urandom_range(0, 6911));
            else if (r < 8) begin
                case ($urandom_range(0, 3))
                    0: cpu_addr = 16'h3FFF;
                    1: cpu_addr = 16'h5AFF;
                    2: cpu_addr = 16'h5B00;
                    default: cpu_addr = 16'h4000;
                endcase
            end else cpu_addr = 16'($urandom);
            cpu_data = 8'($urandom);
            ld_valid = $urandom_range(0, 1);
            ld_addr = ($urandom_range(0, 99) == 0) ? 13'($urandom_range(6912, 8191))
                                                   : 13'($urandom_range(0, 6911));
            ld_data = 8'($urandom);
            clr_start = ($urandom_range(0, 3999) == 0);
            clr_bitmap = 8'($urandom);
            clr_attr = 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
